// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file with a long-latency busy scoreboard.
// Optional starvation guard for the pipeline writeback: define REGARB_FAIR_EN.
module regfile_wb_arbiter #(
    parameter int unsigned N        = 32,
    parameter int unsigned size     = 32,
    parameter int unsigned MAX_WAIT = 4,
    localparam int unsigned AW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_rd,
    input  logic [size-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_rd,
    input  logic [size-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1_q,
    input  logic [AW-1:0]   rs2_q,
    input  logic [AW-1:0]   rd_q,
    output logic            hazard,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [size-1:0] rf_wdata
);

    if (MAX_WAIT == 0) begin : g_bad_cfg
        $error("regfile_wb_arbiter: MAX_WAIT must be at least 1");
    end

    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [size-1:0] rf_wdata_q, rf_wdata_d;
    logic [N-1:0]    busy_q, busy_d;
    logic            force_a;
    logic            grant_a, grant_b;

`ifdef REGARB_FAIR_EN
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // A has waited long enough: it takes the port over a competing B
    assign force_a = (wait_cnt_q == CW'(MAX_WAIT)) && a_valid && b_valid;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!stall) begin
            if (!a_valid || grant_a) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != CW'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_a = 1'b0;
`endif

    // B has fixed priority unless the starvation guard fires
    assign grant_b = !stall && b_valid && !force_a;
    assign grant_a = !stall && a_valid && (!b_valid || force_a);

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign iss_ready = !stall && ((iss_rd == '0) || !busy_q[iss_rd]);

    // No bypass: a B write clearing a register this cycle still reports busy
    assign hazard = ((rs1_q != '0) && busy_q[rs1_q])
                  | ((rs2_q != '0) && busy_q[rs2_q])
                  | ((rd_q  != '0) && busy_q[rd_q]);

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        busy_d     = busy_q;
        if (grant_b) begin
            rf_we_d        = (b_rd != '0);
            rf_waddr_d     = b_rd;
            rf_wdata_d     = b_data;
            busy_d[b_rd]   = 1'b0;
        end else if (grant_a) begin
            rf_we_d    = (a_rd != '0);
            rf_waddr_d = a_rd;
            rf_wdata_d = a_data;
        end
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback (requester A) and the long-latency unit writeback (requester B, divider/load return). It keeps a per-register busy scoreboard for destinations of in-flight long-latency ops and drives a combinational hazard flag back to decode. The write port outputs are registered and feed the register file's RegWrite_en, RDaddr_i and RDdata_i directly.

Parameters:
N, 32, number of architectural registers; address width AW = $clog2(N)
size, 32, data width in bits
MAX_WAIT, 4, consecutive denied cycles of A before A is forced to win (fairness build only)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
stall  input  1  global pipeline stall, same signal the register file receives
a_valid  input  1  pipeline writeback request
a_rd  input  AW  pipeline destination register
a_data  input  size  pipeline write data
a_ready  output  1  pipeline write accepted this cycle
b_valid  input  1  long-latency writeback request
b_rd  input  AW  long-latency destination register
b_data  input  size  long-latency write data
b_ready  output  1  long-latency write accepted this cycle
iss_valid  input  1  long-latency op issuing, marks iss_rd busy
iss_rd  input  AW  destination of the issuing op
iss_ready  output  1  issue accepted (combinational)
rs1_q  input  AW  decode source 1
rs2_q  input  AW  decode source 2
rd_q  input  AW  decode destination
hazard  output  1  any queried register busy (combinational)
rf_we  output  1  register file write enable (registered)
rf_waddr  output  AW  register file write address (registered)
rf_wdata  output  size  register file write data (registered)

Behaviour:
- Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, busy[N-1:0]=0, starvation counter=0. Any accepted but not yet presented write is dropped.
- Handshake: a write transfers when valid && ready. Ready is combinational from valid, stall and arbitration state. Valid must hold with stable rd/data until ready.
- stall=1: a_ready=0, b_ready=0, iss_ready=0. rf_we=0 on the next edge. Busy bits and counter hold.
- Arbitration (stall=0):
  - One valid requester: it is granted.
  - Both valid: B wins (fixed priority) unless the fairness build forces A (see Optional Feature).
  - At most one grant per cycle.
- Write latency: the granted request appears on rf_we/rf_waddr/rf_wdata on the next rising edge, held for exactly one cycle. Next cycle rf_we=1 with back-to-back grants.
- x0: a granted write with rd=0 completes the handshake, but rf_we=0 next cycle. rf_waddr/rf_wdata are don't-care in that case.
- Scoreboard:
  - iss_ready = !stall && (iss_rd==0 || !busy[iss_rd]).
  - iss_valid && iss_ready && iss_rd!=0 sets busy[iss_rd] at the edge.
  - A B grant clears busy[b_rd] at the edge.
  - Set and clear of different registers in the same cycle both take effect.
  - Same-register set+clear cannot occur, because issue is refused while the register is busy.
  - busy[0] is never set.
- A writes do not touch busy. Decode must not send an A write to a busy rd; hazard prevents this.
- hazard = busy[rs1_q] | busy[rs2_q] | busy[rd_q], with any index 0 excluded. It is purely combinational on the current busy state; no same-cycle bypass of a clearing B write.

Optional Feature:
Macro REGARB_FAIR_EN.
- Defined:
  - A saturating counter increments each cycle a_valid=1, stall=0 and A is not granted.
  - It resets to 0 when A is granted or a_valid=0.
  - When the counter equals MAX_WAIT and both are valid, A wins that cycle.
- Not defined: no counter exists and B always has priority over A.

Test Plan:
- Reset then idle: after rst pulse mid-write (grant to A rd=5 in the reset cycle), rf_we=0 and busy=0 on the following edge; hazard=0 for every query.
- Single A write rd=3, data=0xDEADBEEF: a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF; one cycle later rf_we=0.
- Scoreboard: issue rd=7 -> busy; hazard=1 for rs1_q=7; second issue rd=7 has iss_ready=0; B write rd=7 data=0x55 -> rf_we next cycle, hazard=0 after the edge; issue rd=7 now accepted.
- Conflict: A (rd=1) and B (rd=2) both valid for 6 cycles with B re-asserting each cycle. Without REGARB_FAIR_EN, A is never granted. With it and MAX_WAIT=4, A is granted in cycle 5.
- Stall: both valid, stall=1 for 3 cycles -> both readies 0, rf_we=0, iss_ready=0; on release B is granted first.
- x0 drop: A write rd=0, data=0xFFFFFFFF -> a_ready=1, rf_we stays 0; an issue to rd=0 is accepted and hazard stays 0.
